// File: rtl/iic_slave.sv
// iic_slave: I2C target endpoint with a single 7-bit address and no clock stretching.
// The bus is oversampled on clk. START and STOP are detected from the synchronized
// pins. Written bytes go out on rx_data/rx_valid. Read bytes are fetched through
// tx_data/tx_req. Multi-byte bursts work in both directions.
// Optional feature: define IIC_SLAVE_GEN_CALL_EN to also ACK the general-call
// address byte 8'h00, which is then received as a write.
module iic_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic       rw_dir
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] RX_BYTE  = 3'd3;
  localparam logic [2:0] RX_ACK   = 3'd4;
  localparam logic [2:0] TX_BYTE  = 3'd5;
  localparam logic [2:0] TX_ACK   = 3'd6;

  // Synchronizers, previous-sample registers and registered bus events.
  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_p_q, scl_p_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_p_q, sda_p_d;
  logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic start_q, start_d, stop_q, stop_d;

  // Protocol state.
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       rw_dir_q, rw_dir_d;
  logic       enter_tx;
  logic       tx_load;

  // Address compare, including the optional general-call byte.
  function automatic logic addr_match(input logic [7:0] ab);
`ifdef IIC_SLAVE_GEN_CALL_EN
    addr_match = (ab[7:1] == SLAVE_ADDR) || (ab == 8'h00);
`else
    addr_match = (ab[7:1] == SLAVE_ADDR);
`endif
  endfunction

  // Next values for the synchronizers and the edge / START / STOP detectors.
  always_comb begin
    scl_s1_d   = scl;
    scl_s2_d   = scl_s1_q;
    scl_p_d    = scl_s2_q;
    sda_s1_d   = sda;
    sda_s2_d   = sda_s1_q;
    sda_p_d    = sda_s2_q;
    scl_rise_d = scl_s2_q & ~scl_p_q;
    scl_fall_d = ~scl_s2_q & scl_p_q;
    start_d    = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
    stop_d     = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
  end

  // Register the synchronizers and events. An idle bus is high, so reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_p_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_s1_q   <= scl_s1_d;
      scl_s2_q   <= scl_s2_d;
      scl_p_q    <= scl_p_d;
      sda_s1_q   <= sda_s1_d;
      sda_s2_q   <= sda_s2_d;
      sda_p_q    <= sda_p_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  // Protocol FSM. START has priority over STOP, and both have priority over SCL edges.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    phase_d    = phase_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    rw_dir_d   = rw_dir_q;
    enter_tx   = 1'b0;
    tx_load    = 1'b0;

    if (start_q) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_q) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        ADDR: begin
          if (scl_rise_q) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (addr_match(shift_d)) begin
                rw_dir_d = shift_d[0];
                busy_d   = 1'b1;
                phase_d  = 1'b0;
                state_d  = ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall_q) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (rw_dir_q) begin
                enter_tx = 1'b1;
              end else begin
                state_d = RX_BYTE;
              end
            end
          end
        end

        RX_BYTE: begin
          if (scl_rise_q) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = shift_d;
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = RX_ACK;
            end
          end
        end

        RX_ACK: begin
          if (scl_fall_q) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              state_d   = RX_BYTE;
            end
          end
        end

        TX_BYTE: begin
          if (scl_fall_q) begin
            if (bit_cnt_q != 3'd7) begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              state_d   = TX_ACK;
            end
          end
        end

        TX_ACK: begin
          // The master's ACK is sampled on the rise, but the next byte only starts
          // at the following fall, so SDA never changes while SCL is high.
          if (scl_rise_q) begin
            if (sda_s2_q) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall_q && phase_q) begin
            enter_tx = 1'b1;
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase

      // Entry into TX_BYTE: capture tx_data and drive its MSB straight away.
      if (enter_tx) begin
        tx_load   = 1'b1;
        shift_d   = tx_data;
        sda_oe_d  = ~tx_data[7];
        bit_cnt_d = '0;
        phase_d   = 1'b0;
        state_d   = TX_BYTE;
      end
    end
  end

  // Register the protocol state. Reset releases SDA at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      phase_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rw_dir_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      phase_q    <= phase_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      rw_dir_q   <= rw_dir_d;
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_load;
  assign busy     = busy_q;
  assign rw_dir   = rw_dir_q;

endmodule

// File: doc/iic_slave.md
# iic_slave

I2C target (slave) endpoint that answers a single 7-bit address on an open-drain SDA/SCL bus, with no clock stretching. It is the counterpart to `iic_master`. It oversamples the bus on the system clock, detects START and STOP conditions, and ACKs its address. Written bytes are handed to the user logic, and read bytes are fetched from it. Multi-byte bursts are supported in both directions.

## Interface
- `SLAVE_ADDR`, 7'h42: 7-bit target address.
- `clk`  in  1: system clock; must be at least 8× the SCL frequency.
- `rst_n`  in  1: asynchronous, active-low reset.
- `scl`  in  1: bus clock; input only, never driven.
- `sda`  inout  1: open-drain; drives 0 or `z` only.
- `tx_data`  in  8: byte to return on a read; sampled when `tx_req` pulses.
- `rx_data`  out  8: last byte written by the master.
- `rx_valid`  out  1: one-cycle pulse; `rx_data` is new.
- `tx_req`  out  1: one-cycle pulse; `tx_data` is captured this cycle.
- `busy`  out  1: high from an address match until STOP or abort.
- `rw_dir`  out  1: R/W bit of the current addressed transfer (1 = read).

## Operation
- `scl` and `sda` each pass through a 2-flop synchronizer. Edges are detected on the synchronized copies: rise, fall, and sda-change-while-scl-high.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
- START (or repeated START) from any state: clear the bit counter, release SDA, go to `ADDR`.
- STOP from any state: go to `IDLE`, release SDA, drop `busy`.
- States:
  - `IDLE`: wait for START.
  - `ADDR`: shift 8 bits MSB first on SCL rise. After the 8th bit, compare bits [7:1] to `SLAVE_ADDR`.
    - Match: latch `rw_dir`, set `busy`, go to `ADDR_ACK`.
    - Mismatch: go to `IDLE` and ignore the bus until the next START.
  - `ADDR_ACK`: on the SCL fall after the 8th bit, drive SDA low. Release on the next SCL fall. Then go to `RX_BYTE` (write) or `TX_BYTE` (read).
  - `RX_BYTE`: shift 8 bits on SCL rise. On the 8th rise, load `rx_data` and pulse `rx_valid`. Go to `RX_ACK`.
  - `RX_ACK`: drive SDA low for one SCL period (fall to fall). Return to `RX_BYTE`.
  - `TX_BYTE`: on entry, pulse `tx_req` and load the shift register from `tx_data`.
    - Put each bit on SDA at the SCL fall: drive low for 0, release for 1. The first bit goes out at the fall that ends the ACK.
    - After 8 bits, release SDA at the next fall and go to `TX_ACK`.
  - `TX_ACK`: sample SDA on SCL rise.
    - 0 (master ACK): go to `TX_BYTE` for the next byte.
    - 1 (NACK): go to `IDLE`, clear `busy`. SDA stays released.
- There is no master-side length limit. `rx_data` holds its value until the next `rx_valid`.

## Timing
- Reset values: `sda` = `z`, `rx_data` = 8'h00, `rx_valid` = 0, `tx_req` = 0, `busy` = 0, `rw_dir` = 0, state = `IDLE`.
- Detection latency is 3 `clk` from a bus pin change to the internal edge: 2 sync flops plus the edge register.
- SDA output changes 1 `clk` after an internal SCL-fall detect, well inside SCL low.
- `rx_valid` asserts 1 `clk` after the internal SCL rise of bit 0 of the byte.
- `tx_req` asserts on the `clk` the FSM enters `TX_BYTE`, which is the internal SCL fall ending the ACK. `tx_data` must be stable on that `clk`.
- Simultaneous START detect and SCL edge on the same `clk`: START wins.
- Reset mid-transfer: SDA releases immediately (asynchronous). The block stays in `IDLE` until a fresh START.
- SDA is never driven while SCL is high, except that a held ACK or 0 bit persists through the high phase.

## Configuration
- `IIC_SLAVE_GEN_CALL_EN`
  - Defined: address byte 8'h00 (general call, write) is also ACKed. Following bytes are received exactly like addressed writes, `rw_dir` = 0. Address 8'h01 is not ACKed.
  - Undefined: only `SLAVE_ADDR` is ACKed, and 8'h00 is treated as a mismatch.

## Test plan
- Write 0x42/W, data 0xAA, STOP -> ACK on both bytes; `rx_valid` one pulse with `rx_data` = 0xAA; `busy` falls after STOP.
- Read 0x42/R with `tx_data` = 0x3C, master NACK, STOP -> SDA bit sequence 0,0,1,1,1,1,0,0; one `tx_req` pulse; return to `IDLE`.
- Address 0x43/W, data 0x55 -> SDA never driven low; no `rx_valid`; `busy` stays 0.
- Two-byte read: `tx_data` 0x12 then 0x34 across the master ACK -> two `tx_req` pulses; bytes appear in order; ends on NACK.
- `rst_n` low during the data phase of a write of 0x55 -> SDA released within the same `clk`; no `rx_valid`; the next 0x42/W transfer of 0xAA succeeds.
- With `IIC_SLAVE_GEN_CALL_EN`: address 0x00, data 0x0F -> ACKed, `rx_data` = 0x0F. Without the macro: NACK, no `rx_valid`.
